// File: rtl/chiplet_pkg.sv
// Shared types and helpers for the chiplet link scheduler and its round-robin picker.
package chiplet_pkg;

    // Payload width of the link flit record; the scheduler's FLIT_W defaults to this.
    localparam int FLIT_W_DEFAULT = 32;

    // One link flit as seen by the serializer: markers plus payload.
    typedef struct packed {
        logic                      head;
        logic                      tail;
        logic [FLIT_W_DEFAULT-1:0] data;
    } flit_t;

    // IDLE arbitrates between packet heads; LOCKED follows one owner until its tail.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    // Width of an index into n items, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chiplet_rr_pick.sv
// Combinational N-way round-robin picker: searches upward from the entry after ptr.
module chiplet_rr_pick
    import chiplet_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] cand;

    // Walk ptr+1, ptr+2, ... (mod N) and grant the first requester encountered.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!gnt_valid && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chiplet_link_scheduler.sv
// Shares one inter-chiplet link between TILES*PLANES flit streams using round-robin
// packet arbitration, a head-to-tail wormhole lock and credit-based flow control.
module chiplet_link_scheduler
    import chiplet_pkg::*;
#(
    parameter int TILES   = 2,
    parameter int PLANES  = 2,
    parameter int FLIT_W  = 32,
    parameter int CREDITS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [TILES*PLANES*FLIT_W-1:0]       in_data,
    input  logic [TILES*PLANES-1:0]              in_head,
    input  logic [TILES*PLANES-1:0]              in_tail,
    input  logic [TILES*PLANES-1:0]              in_valid,
    output logic [TILES*PLANES-1:0]              in_ready,
    output logic [FLIT_W-1:0]                    out_data,
    output logic                                 out_head,
    output logic                                 out_tail,
    output logic [idx_w(TILES*PLANES)-1:0]       out_src,
    output logic                                 out_valid,
    input  logic                                 credit_in,
    output logic [$clog2(CREDITS+1)-1:0]         credits,
    output logic                                 busy,
    output logic                                 err
);

    localparam int N  = TILES * PLANES;
    localparam int IW = idx_w(N);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);

    sched_state_t  state, state_next;
    logic [IW-1:0] rr_ptr, rr_ptr_next;
    logic [IW-1:0] owner, owner_next;
    logic [CW-1:0] credit_cnt;
    logic          err_q;

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;

    logic          has_credit;
    logic [N-1:0]  ready;
    logic [IW-1:0] xfer_idx;
    logic          xfer;
    logic          proto_err;
    logic          credit_overflow;

    logic [FLIT_W-1:0] sel_data;
    logic              sel_head;
    logic              sel_tail;

    assign req        = in_valid & in_head;
    assign has_credit = (credit_cnt != '0);

    chiplet_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Next-state, grant and protocol-error decode for the IDLE/LOCKED wormhole FSM.
    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        owner_next  = owner;
        ready       = '0;
        xfer_idx    = '0;
        proto_err   = 1'b0;
        case (state)
            IDLE: begin
                if (|(in_valid & ~in_head)) begin
                    proto_err = 1'b1;
                end
                if (gnt_valid && has_credit && !rst) begin
                    ready    = gnt;
                    xfer_idx = gnt_idx;
                    if (in_tail[gnt_idx]) begin
                        rr_ptr_next = gnt_idx;
                    end else begin
                        state_next = LOCKED;
                        owner_next = gnt_idx;
                    end
                end
            end
            LOCKED: begin
                xfer_idx = owner;
                if (in_valid[owner] && has_credit && !rst) begin
                    ready[owner] = 1'b1;
                    if (in_head[owner]) begin
                        proto_err = 1'b1;
                    end
                    if (in_tail[owner]) begin
                        state_next  = IDLE;
                        rr_ptr_next = owner;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign xfer     = |ready;
    assign in_ready = ready;

    assign sel_data = in_data[int'(xfer_idx)*FLIT_W +: FLIT_W];
    assign sel_head = in_head[xfer_idx];
    assign sel_tail = in_tail[xfer_idx];

    // A returned credit with nothing consumed while already full cannot be stored.
    assign credit_overflow = credit_in && !xfer && (credit_cnt == CREDITS_MAX);

    // FSM state, round-robin pointer and wormhole owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= IW'(N - 1);
            owner  <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            owner  <= owner_next;
        end
    end

    // Credit counter: spend one per transferred flit, regain one per credit_in pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CREDITS_MAX;
        end else if (xfer && !credit_in) begin
            credit_cnt <= credit_cnt - CW'(1);
        end else if (credit_in && !xfer && !credit_overflow) begin
            credit_cnt <= credit_cnt + CW'(1);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (proto_err || credit_overflow) begin
            err_q <= 1'b1;
        end
    end

    // Registered link output: capture the transferred flit, valid for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_head  <= 1'b0;
            out_tail  <= 1'b0;
            out_src   <= '0;
        end else begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel_data;
                out_head <= sel_head;
                out_tail <= sel_tail;
                out_src  <= xfer_idx;
            end
        end
    end

    assign credits = credit_cnt;
    assign busy    = (state == LOCKED);
    assign err     = err_q;

`ifndef SYNTHESIS
    logic prev_xfer;

    // Remember whether the previous cycle moved a flit, for the output-latency invariant.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_xfer <= 1'b0;
        end else begin
            prev_xfer <= xfer;
        end
    end

    // Handshake and credit invariants that must hold on every cycle outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(in_ready));
            assert (credit_cnt <= CREDITS_MAX);
            assert (!out_valid || prev_xfer);
        end
    end
`endif

endmodule

// File: doc/chiplet_link_scheduler.md
Name: chiplet_link_scheduler

Overview:
- Shares one inter-chiplet output link between N = TILES*PLANES input flit streams.
- Applies round-robin packet arbitration with a wormhole lock from head to tail, and credit-based flow control toward the link receiver.
- Sits between the per-tile/per-plane router output ports and the chiplet link serializer.
- Output is registered; one flit per cycle at most.

Parameters:
- TILES, 2, number of tiles feeding the link
- PLANES, 2, NoC planes per tile
- FLIT_W, 32, flit payload width in bits
- CREDITS, 4, receiver buffer depth; initial and maximum credit count

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_data  in  N*FLIT_W  payload per input; input i occupies bits [i*FLIT_W +: FLIT_W]
- in_head  in  N  head marker per input
- in_tail  in  N  tail marker per input; head and tail both set means a single-flit packet
- in_valid  in  N  flit valid per input
- in_ready  out  N  flit accepted this cycle; combinational, at most one bit set
- out_data  out  FLIT_W  registered link payload
- out_head  out  1  registered head marker
- out_tail  out  1  registered tail marker
- out_src  out  max(1,$clog2(N))  registered source index of the flit
- out_valid  out  1  registered link valid
- credit_in  in  1  one-cycle pulse; receiver freed one slot
- credits  out  $clog2(CREDITS+1)  current credit count
- busy  out  1  FSM is in LOCKED
- err  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, active-high rst, clk) values:
  - out_valid=0, out_head=0, out_tail=0, out_data=0, out_src=0
  - credits=CREDITS, busy=0, err=0
  - FSM=IDLE, rr_ptr=N-1, so input 0 has highest priority after reset
  - in_ready=0 while rst is high
- Transfer condition: xfer = in_valid[g] & in_ready[g].
  - Registers capture the flit on the next edge, giving out_valid=1 one cycle later (latency 1).
  - out_valid=0 on any cycle that follows a cycle without xfer.
- Credits:
  - xfer without credit_in: decrement.
  - credit_in without xfer: increment.
  - Both together: unchanged.
  - credit_in at CREDITS: count saturates and err is set.
  - in_ready is forced to 0 whenever credits==0, so the count never underflows.
- FSM IDLE:
  - Requesters are inputs with in_valid & in_head.
  - Grant goes to the first requester at index rr_ptr+1, rr_ptr+2, ... modulo N.
  - Grant is zero-delay: in_ready[g]=1 in the same cycle if credits>0.
  - Granted head with tail also set: remain IDLE and set rr_ptr=g.
  - Granted head without tail: go to LOCKED, set owner=g, busy=1 from the next cycle.
  - in_valid & ~in_head on any input while IDLE: ignored (not readied) and err is set.
- FSM LOCKED:
  - in_ready[owner] = in_valid[owner] & (credits>0); all other in_ready are 0.
  - Owner presents a flit with in_head=1: accepted, and err is set.
  - Owner tail transferred: go to IDLE, set rr_ptr=owner.
  - The next arbitration happens in the cycle after the tail, so there is no same-cycle re-grant.
- Stalls:
  - Owner in_valid=0, or credits==0: hold LOCKED indefinitely with no timeout.
  - Other requesters wait.
- Reset mid-packet: all state returns to reset values immediately. The partially sent packet is abandoned; the link receiver is reset by the same rst.
- Assertions (non-synthesis):
  - $onehot0(in_ready)
  - credits<=CREDITS
  - out_valid implies the previous cycle had xfer

Decomposition:
- chiplet_pkg holds:
  - typedef flit_t (payload + head + tail)
  - function idx_w(n) = max(1,$clog2(n))
  - FSM enum sched_state_t {IDLE, LOCKED}
- One sub-module, chiplet_rr_pick:
  - Combinational N-way round-robin picker.
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N], gnt_idx, gnt_valid.
  - Instantiated once, for the IDLE arbitration.
- The credit counter and FSM stay in the top module.

Test Plan:
- After reset, inputs 0 and 2 each present a single-flit head+tail, held valid; credit_in is pulsed every cycle from cycle 2 onward.
  - Cycle 0: in_ready=4'b0001.
  - Cycle 1: out_src=0, out_valid=1, in_ready=4'b0100.
  - Cycle 2: out_src=2.
  - credits goes 4→3→2 over cycles 1–2, then holds at 2 while one credit returns per cycle.
- Input 1 sends a 3-flit packet while input 3 holds a head.
  - Expect in_ready only on bit 1 for 3 consecutive cycles and busy=1 during the body.
  - Input 3 is granted in the cycle after the tail; out_src sequence is 1,1,1,3.
- No credit_in; input 0 streams 6 flits.
  - Expect exactly 4 transfers, then credits=0 and in_ready=0.
  - One credit_in pulse allows exactly 1 more flit.
  - credit_in and xfer in the same cycle leave credits unchanged.
- All 4 inputs continuously offer single-flit packets with credits replenished.
  - Grant order is 0,1,2,3,0,1,...
  - Each source receives 25% of flits over 40 cycles.
- Protocol errors:
  - A body flit while IDLE leaves in_ready=0 and sets err=1.
  - credit_in at credits=4 keeps credits=4 and sets err=1.
  - err stays 1 until rst.
- Assert rst in the middle of a 4-flit packet (after 2 flits).
  - Next cycle: busy=0, credits=4, out_valid=0, err=0.
  - Input 0 is then granted first.
